hex_seg_capture: RTL and testbench

//  Reverse direction of the hex-to-7-segment path: monitors a multiplexed 7-segment display bus
//  and recovers the hex nibble shown on each digit. Waits for the bus to be stable, decodes
//  the segment pattern, stores one nibble per digit and flags a complete frame.

---
 rtl/hex_seg_capture_if.sv | 31 +++
 rtl/hex_seg_capture.sv | 134 +++++++++++++
 tb/tb_hex_seg_capture.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_seg_capture_if.sv
`default_nettype none
// ============================================================================
//  Module      : hex_seg_capture_if
//  Description : Display-bus tap interface. It carries the multiplexed
//                7-segment lines and digit enables into the capture block,
//                and the recovered nibbles and status pulses back out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hex_seg_capture_if #(
    parameter int N_DIG = 4
);
    logic [0:6]         seg_in;         // a..g, index 0 = a, active-low
    logic [N_DIG-1:0]   dig_sel;        // digit enables, active-low
    logic [4*N_DIG-1:0] digitos;        // nibble i at [4*i+3:4*i]
    logic [N_DIG-1:0]   invalido;       // digit i holds blank/unknown pattern
    logic               quadro_valido;  // frame-complete pulse
    logic               erro_sel;       // bad digit-select pulse

    // Side that drives the display bus and observes the readback
    modport master (
        output seg_in, dig_sel,
        input  digitos, invalido, quadro_valido, erro_sel
    );

    // Capture block side
    modport slave (
        input  seg_in, dig_sel,
        output digitos, invalido, quadro_valido, erro_sel
    );
endinterface
`default_nettype wire

// File: rtl/hex_seg_capture.sv
`default_nettype none
// ============================================================================
//  Module      : hex_seg_capture
//  Description : Monitors a multiplexed 7-segment display bus, waits for
//                ESTAVEL identical samples, decodes the segment pattern back
//                to a hex nibble and stores it per digit. Flags a frame once
//                every digit has been captured.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_seg_capture #(
    parameter int N_DIG   = 4,
    parameter int ESTAVEL = 3
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    hex_seg_capture_if.slave  bus
);

    localparam int               c_W       = 7 + N_DIG;
    localparam logic [7:0]       c_ESTAVEL = 8'(ESTAVEL);
    localparam logic [N_DIG-1:0] c_ONE     = N_DIG'(1);

    localparam logic [0:0] S_CONTA   = 1'b0;
    localparam logic [0:0] S_TRAVADO = 1'b1;

    logic [0:0]         r_state;
    logic [c_W-1:0]     r_amostra;
    logic [7:0]         r_cnt;
    logic [N_DIG-1:0]   r_mask;
    logic [4*N_DIG-1:0] r_digitos;
    logic [N_DIG-1:0]   r_invalido;
    logic               r_quadro;
    logic               r_erro;

    logic [c_W-1:0]     w_in;
    logic               w_diff;
    logic [7:0]         w_cnt_nxt;
    logic               w_stable;
    logic [N_DIG-1:0]   w_sel;
    logic               w_onehot;
    logic [3:0]         w_nib;
    logic               w_inv;

    assign w_in      = {bus.seg_in, bus.dig_sel};
    assign w_diff    = (w_in != r_amostra);
    // A change always restarts the run at 1, even on the edge stability would be reached
    assign w_cnt_nxt = w_diff ? 8'd1 : ((r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1);
    assign w_stable  = (r_state == S_CONTA) && !w_diff && (w_cnt_nxt == c_ESTAVEL);

    // Active-high copy of the enables; valid when exactly one bit is set
    assign w_sel    = ~bus.dig_sel;
    assign w_onehot = (w_sel != '0) && ((w_sel & (w_sel - c_ONE)) == '0);

    // Segment pattern (a..g, active-low) back to its hex nibble
    always_comb begin
        w_nib = 4'h0;
        w_inv = 1'b0;
        case (bus.seg_in)
            7'b0000001: w_nib = 4'h0;
            7'b1001111: w_nib = 4'h1;
            7'b0010010: w_nib = 4'h2;
            7'b0000110: w_nib = 4'h3;
            7'b1001100: w_nib = 4'h4;
            7'b0100100: w_nib = 4'h5;
            7'b0100000: w_nib = 4'h6;
            7'b0001111: w_nib = 4'h7;
            7'b0000000: w_nib = 4'h8;
            7'b0000100: w_nib = 4'h9;
            7'b0001000: w_nib = 4'hA;
            7'b1100000: w_nib = 4'hB;
            7'b0110001: w_nib = 4'hC;
            7'b1000010: w_nib = 4'hD;
            7'b0110000: w_nib = 4'hE;
            7'b0111000: w_nib = 4'hF;
            default:    w_inv = 1'b1;
        endcase
    end

    // Stability tracking: sample history, run counter and count/lock FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_CONTA;
            r_amostra <= '0;
            r_cnt     <= 8'd0;
        end else begin
            r_amostra <= w_in;
            r_cnt     <= w_cnt_nxt;
            case (r_state)
                S_CONTA:   if (w_stable) r_state <= S_TRAVADO;
                S_TRAVADO: if (w_diff)   r_state <= S_CONTA;
                default:   r_state <= S_CONTA;
            endcase
        end
    end

    // Capture on stability: store nibble, track frame mask, raise pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask     <= '0;
            r_digitos  <= '0;
            r_invalido <= '1;
            r_quadro   <= 1'b0;
            r_erro     <= 1'b0;
        end else begin
            r_quadro <= 1'b0;
            r_erro   <= 1'b0;
            if (w_stable) begin
                if (w_onehot) begin
                    for (int i = 0; i < N_DIG; i++) begin
                        if (w_sel[i]) begin
                            r_digitos[4*i +: 4] <= w_nib;
                            r_invalido[i]       <= w_inv;
                        end
                    end
                    if ((r_mask | w_sel) == '1) begin
                        r_mask   <= '0;
                        r_quadro <= 1'b1;
                    end else begin
                        r_mask <= r_mask | w_sel;
                    end
                end else begin
                    r_erro <= 1'b1;
                end
            end
        end
    end

    assign bus.digitos       = r_digitos;
    assign bus.invalido      = r_invalido;
    assign bus.quadro_valido = r_quadro;
    assign bus.erro_sel      = r_erro;

endmodule
`default_nettype wire

// File: tb/tb_hex_seg_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_seg_capture
//  Description : Self-checking bench for hex_seg_capture: decode table
//                vectors, directed corner sequences and randomized traffic
//                against a run-length reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_seg_capture;

    localparam int N_DIG   = 4;
    localparam int ESTAVEL = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    hex_seg_capture_if #(.N_DIG(N_DIG)) bus ();

    hex_seg_capture #(
        .N_DIG   (N_DIG),
        .ESTAVEL (ESTAVEL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [6:0] seg;
        logic [3:0] nib;
        logic       inv;
    } vec_t;

    vec_t vecs [18];

    logic [6:0] pat_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    int n_checks = 0;
    int n_err    = 0;
    int qv_count = 0;
    int er_count = 0;

    // Reference model: run length of identical {seg,sel} samples
    logic [6+N_DIG:0] m_prev;
    int               m_run;
    logic [3:0]       m_dig [N_DIG];
    logic [N_DIG-1:0] m_inv;
    logic [N_DIG-1:0] m_mask;
    logic             m_qv;
    logic             m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] decode(input logic [6:0] s);
        for (int k = 0; k < 16; k++)
            if (pat_tab[k] == s) return {1'b0, 4'(k)};
        return {1'b1, 4'h0};
    endfunction

    function automatic logic [4*N_DIG-1:0] exp_digitos();
        logic [4*N_DIG-1:0] e;
        for (int k = 0; k < N_DIG; k++) e[4*k +: 4] = m_dig[k];
        return e;
    endfunction

    task automatic model_reset();
        m_prev = '0;
        m_run  = 0;
        for (int k = 0; k < N_DIG; k++) m_dig[k] = 4'h0;
        m_inv  = '1;
        m_mask = '0;
        m_qv   = 1'b0;
        m_err  = 1'b0;
    endtask

    // One clock edge: advance the model on the sampled inputs, then compare
    task automatic tick();
        logic [6+N_DIG:0] cur;
        logic [6:0]       s;
        logic [4:0]       d;
        int               idx;
        @(posedge clk);
        s   = bus.seg_in;
        cur = {bus.seg_in, bus.dig_sel};
        if (cur == m_prev) m_run++;
        else               m_run = 1;
        m_prev = cur;
        m_qv   = 1'b0;
        m_err  = 1'b0;
        if (m_run == ESTAVEL) begin
            if ($countones(~bus.dig_sel) == 1) begin
                idx = 0;
                for (int k = 0; k < N_DIG; k++) if (!bus.dig_sel[k]) idx = k;
                d = decode(s);
                m_dig[idx]  = d[3:0];
                m_inv[idx]  = d[4];
                m_mask[idx] = 1'b1;
                if (&m_mask) begin
                    m_mask = '0;
                    m_qv   = 1'b1;
                end
            end else begin
                m_err = 1'b1;
            end
        end
        #1;
        check("digitos",       bus.digitos,       exp_digitos());
        check("invalido",      bus.invalido,      m_inv);
        check("quadro_valido", bus.quadro_valido, m_qv);
        check("erro_sel",      bus.erro_sel,      m_err);
        if (bus.quadro_valido) qv_count++;
        if (bus.erro_sel)      er_count++;
    endtask

    task automatic apply(input logic [6:0] s, input logic [N_DIG-1:0] sel, input int n);
        bus.seg_in  = s;
        bus.dig_sel = sel;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rst_digitos",  bus.digitos,       64'h0);
        check("rst_invalido", bus.invalido,      64'hF);
        check("rst_quadro",   bus.quadro_valido, 64'h0);
        check("rst_erro",     bus.erro_sel,      64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [4*N_DIG-1:0] saved;
        int                 q0;
        int                 dsel;

        vecs[0]  = '{7'b0000001, 4'h0, 1'b0};
        vecs[1]  = '{7'b1001111, 4'h1, 1'b0};
        vecs[2]  = '{7'b0010010, 4'h2, 1'b0};
        vecs[3]  = '{7'b0000110, 4'h3, 1'b0};
        vecs[4]  = '{7'b1001100, 4'h4, 1'b0};
        vecs[5]  = '{7'b0100100, 4'h5, 1'b0};
        vecs[6]  = '{7'b0100000, 4'h6, 1'b0};
        vecs[7]  = '{7'b0001111, 4'h7, 1'b0};
        vecs[8]  = '{7'b0000000, 4'h8, 1'b0};
        vecs[9]  = '{7'b0000100, 4'h9, 1'b0};
        vecs[10] = '{7'b0001000, 4'hA, 1'b0};
        vecs[11] = '{7'b1100000, 4'hB, 1'b0};
        vecs[12] = '{7'b0110001, 4'hC, 1'b0};
        vecs[13] = '{7'b1000010, 4'hD, 1'b0};
        vecs[14] = '{7'b0110000, 4'hE, 1'b0};
        vecs[15] = '{7'b0111000, 4'hF, 1'b0};
        vecs[16] = '{7'b1111111, 4'h0, 1'b1};
        vecs[17] = '{7'b1110000, 4'h0, 1'b1};

        bus.seg_in  = 7'b1111111;
        bus.dig_sel = 4'b1111;
        model_reset();
        do_reset();

        // 1: digit 0 shows 3, captured on the 3rd edge, held without rewrite
        apply(7'b0000110, 4'b1110, 3);
        check("t1_nibble", bus.digitos[3:0], 64'h3);
        check("t1_inv",    bus.invalido[0],  64'h0);
        apply(7'b0000110, 4'b1110, 3);

        // 2: full frame 1,A,C,F -> one pulse
        do_reset();
        q0 = qv_count;
        apply(7'b1001111, 4'b1110, 4);
        apply(7'b0001000, 4'b1101, 4);
        apply(7'b0110001, 4'b1011, 4);
        apply(7'b0111000, 4'b0111, 4);
        check("t2_frame_pulses", qv_count - q0, 64'd1);
        check("t2_digitos",      bus.digitos,   64'hFCA1);

        // 3: 2-edge glitch is rejected, following 3-edge value captured
        apply(7'b0010010, 4'b1101, 2);
        check("t3_glitch", bus.digitos[7:4], 64'hA);
        apply(7'b1001100, 4'b1101, 3);
        check("t3_capture", bus.digitos[7:4], 64'h4);

        // 4: non-one-hot selects give error pulses and no writes
        saved = bus.digitos;
        apply(7'b1001100, 4'b1100, 3);
        check("t4_err_1100", bus.erro_sel, 64'h1);
        check("t4_keep_1100", bus.digitos, saved);
        apply(7'b1001100, 4'b1111, 3);
        check("t4_err_1111", bus.erro_sel, 64'h1);
        check("t4_keep_1111", bus.digitos, saved);
        apply(7'b1001100, 4'b1111, 1);

        // 5: blank and unknown patterns flag invalid but still fill the mask
        apply(7'b1111111, 4'b1011, 3);
        apply(7'b1110000, 4'b0111, 3);
        check("t5_inv",     bus.invalido[3:2], 64'h3);
        check("t5_nibbles", bus.digitos[15:8], 64'h0);
        apply(7'b0000001, 4'b1110, 3);
        check("t5_frame", bus.quadro_valido, 64'h1);
        apply(7'b0000001, 4'b1110, 1);

        // 6: reset discards a partial frame
        do_reset();
        apply(7'b1001111, 4'b1110, 3);
        apply(7'b0010010, 4'b1101, 3);
        apply(7'b0000110, 4'b1011, 3);
        do_reset();
        q0 = qv_count;
        apply(7'b1001100, 4'b0111, 5);
        check("t6_no_frame", qv_count - q0, 64'd0);

        // Decode table walk, rotating across digits
        do_reset();
        for (int i = 0; i < 18; i++) begin
            dsel = i % N_DIG;
            apply(vecs[i].seg, ~(N_DIG'(1) << dsel), ESTAVEL);
            check("tbl_nibble", bus.digitos[4*dsel +: 4], vecs[i].nib);
            check("tbl_inv",    bus.invalido[dsel],       vecs[i].inv);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [6:0]       s;
            logic [N_DIG-1:0] sel;
            if ($urandom_range(0, 99) < 85) s = pat_tab[$urandom_range(0, 15)];
            else                            s = 7'($urandom);
            if ($urandom_range(0, 99) < 80) sel = ~(N_DIG'(1) << $urandom_range(0, N_DIG-1));
            else                            sel = N_DIG'($urandom);
            apply(s, sel, $urandom_range(1, 5));
            if ($urandom_range(0, 59) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
